rr_stream_mux: RTL and testbench



---
 rtl/rr_stream_mux.sv | 58 +++++
 tb/tb_rr_stream_mux.sv | 108 ++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream mux with round-robin or fixed-priority arbitration and a registered output stage
module rr_stream_mux #(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d, last_q, last_d, win, idx;
  logic out_valid_q, out_valid_d, load_en, found, take;
  // search for the winner starting after the last grant (or at 0 in priority mode) and form next state
  always_comb begin
    load_en = !out_valid_q || out_ready;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = SEL_W'(mode ? i : (int'(last_q) + 1 + i) % N_CH);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    take = found && load_en;
    in_ready = (take && !rst) ? N_CH'(1) << win : '0;
    out_valid_d = load_en ? found : out_valid_q;
    out_data_d = take ? WIDTH'(in_data >> (int'(win) * WIDTH)) : out_data_q;
    out_ch_d = take ? win : out_ch_q;
    last_d = take ? win : last_q;
  end
  // output register and grant pointer; reset drops any held beat and points at the last channel
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      last_q <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      last_q <= last_d;
    end
  end
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed test-plan sequences plus random traffic checked against a behavioural model
module tb_rr_stream_mux;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, mode, out_valid, out_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_ready;
  logic [W-1:0] out_data;
  logic [1:0] out_ch;
  int n_chk = 0, n_err = 0;
  logic m_valid;
  logic [W-1:0] m_data;
  int m_ch, m_last;
  logic [N*W-1:0] td = {8'h13, 8'h12, 8'h11, 8'h10};

  always #5 clk = ~clk;

  rr_stream_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      int c = mode ? k : (m_last + 1 + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic md, input logic [N-1:0] v, input logic ordy, input logic [N*W-1:0] d);
    int w;
    logic ld;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_ch", out_ch, m_ch);
    rst = r; mode = md; in_valid = v; out_ready = ordy; in_data = d;
    #1;
    w = winner();
    ld = !m_valid || ordy;
    chk("in_ready", in_ready, (!r && ld && w >= 0) ? (32'd1 << w) : 32'd0);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N - 1;
    end else if (ld) begin
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_data = d[w*W +: W]; m_ch = w; m_last = w;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_to_ch2();
    step(1, 0, '0, 1, td);
    repeat (3) step(0, 0, '1, 1, td);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = '1; out_ready = 1'b1; in_data = td;
    @(posedge clk);
    #1;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N - 1;
    step(1, 0, '1, 1, td);
    step(1, 0, '1, 1, td);
    chk("rst_ready", in_ready, 0);
    step(0, 0, '1, 1, td);
    chk("rel_ch", out_ch, 0);
    chk("rel_data", out_data, 8'h10);
    repeat (7) step(0, 0, '1, 1, td);
    step(1, 0, '0, 1, td);
    repeat (4) step(0, 0, 4'b1010, 1, td);
    fill_to_ch2();
    chk("bp_ch", out_ch, 2);
    repeat (3) step(0, 0, '1, 0, td);
    chk("bp_hold", out_data, 8'h12);
    step(0, 0, '1, 1, td);
    chk("bp_next", out_ch, 3);
    repeat (3) step(0, 1, 4'b1100, 1, td);
    repeat (3) step(0, 1, 4'b1101, 1, td);
    chk("fp_ch", out_ch, 0);
    fill_to_ch2();
    step(0, 0, '1, 0, td);
    step(1, 0, '1, 0, td);
    chk("mrst_valid", out_valid, 0);
    step(0, 0, '1, 1, td);
    chk("mrst_ch", out_ch, 0);
    repeat (3000) begin
      logic [N*W-1:0] rd;
      for (int k = 0; k < N; k++) rd[k*W +: W] = W'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0 ? !mode : mode,
           N'($urandom), $urandom_range(0, 3) != 0, rd);
    end
    chk("end_valid", out_valid, m_valid);
    chk("end_data", out_data, m_data);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
